// File: rtl/oport_uart_tx_pkg.sv
// oport_uart_tx_pkg: shared FSM state encoding and 8N1 frame constants
package oport_uart_tx_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;
   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam int   FRAME_BITS = 10;
endpackage

// File: rtl/oport_fifo.sv
// oport_fifo: first-word-fall-through byte buffer with registered full/empty flags
module oport_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count, count_n;
   logic              push, pop;
   // a write against a full buffer is dropped even when a pop lands in the same cycle
   assign push    = wr_en && !full;
   assign pop     = rd_en && !empty;
   assign count_n = count + CW'(push) - CW'(pop);
   assign rd_data = mem[rd_ptr];
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
         count  <= count_n;
         full   <= count_n == CW'(FIFO_DEPTH);
         empty  <= count_n == '0;
      end
   end
endmodule

// File: rtl/oport_uart_tx.sv
// oport_uart_tx: buffers bytes written to the core's oport and sends them as 8N1 UART frames
module oport_uart_tx
   import oport_uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4,
   parameter int DATA_W       = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic              full,
   output logic              busy,
   output logic              overflow,
   output logic              tx
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_W);
   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] shreg, shreg_n, head;
   logic              empty, pop, fire, bit_done, tx_n;
   assign fire     = cnt == CNT_W'(CLKS_PER_BIT - 1);
   assign bit_done = state == DATA && fire;
   oport_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (pop),
      .rd_data (head),
      .full    (full),
      .empty   (empty)
   );
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         idx      <= '0;
         shreg    <= '0;
         tx       <= STOP_BIT;
         overflow <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= (state == IDLE || fire) ? '0 : cnt + 1'b1;
         idx      <= state == DATA ? idx + IDX_W'(fire) : '0;
         shreg    <= shreg_n;
         tx       <= tx_n;
         overflow <= overflow | (wr_en & full);
      end
   end
   always_comb begin
      state_n = state;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            pop     = !empty;
            state_n = empty ? IDLE : START;
         end
         START: state_n = fire ? DATA : START;
         DATA:  state_n = (fire && idx == IDX_W'(DATA_W - 1)) ? STOP : DATA;
         STOP: begin
            pop     = fire && !empty;
            state_n = !fire ? STOP : empty ? IDLE : START;
         end
         default: state_n = IDLE;
      endcase
      shreg_n = pop ? head : bit_done ? shreg >> 1 : shreg;
   end
   // tx is registered from the next state so the line never glitches
   always_comb begin
      tx_n = state_n == START ? START_BIT : state_n == DATA ? shreg_n[0] : STOP_BIT;
      busy = state != IDLE || !empty;
   end
endmodule

// File: tb/tb_oport_uart_tx.sv
// tb_oport_uart_tx: table-driven writes with a UART-decoding scoreboard plus corner-case sequences
module tb_oport_uart_tx;
   import oport_uart_tx_pkg::*;
   localparam int CPB = 4;
   localparam int FRAME_CYC = FRAME_BITS * CPB;
   typedef struct {
      int         grp;
      logic [7:0] data;
      logic       exp_full;
   } vec_t;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       full, busy, overflow, tx;
   int         tests = 0;
   int         fails = 0;
   int         cyc = 0;
   bit         mon_active = 1'b0;
   logic [7:0] sb[$];
   int         starts[$];
   vec_t       vecs[$];
   always #5 clk = ~clk;
   oport_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .DATA_W(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .full     (full),
      .busy     (busy),
      .overflow (overflow),
      .tx       (tx)
   );
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask
   // decodes frames off tx and compares each byte against the scoreboard
   task automatic monitor();
      int n = 0;
      int k;
      logic [7:0] rx = 8'h00;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset) mon_active = 1'b0;
         else if (!mon_active) begin
            if (!tx) begin
               mon_active = 1'b1;
               n = 0;
               starts.push_back(cyc);
            end
         end else n++;
         if (mon_active && n % CPB == CPB / 2) begin
            k = n / CPB;
            if (k == 0) check("start_bit", tx, 0);
            else if (k <= 8) rx[k-1] = tx;
            else begin
               check("stop_bit", tx, 1);
               check("sb_has_entry", sb.size() != 0, 1);
               if (sb.size() != 0) check("rx_byte", rx, sb.pop_front());
            end
         end
         if (mon_active && n == FRAME_CYC - 1) mon_active = 1'b0;
      end
   endtask
   task automatic apply_group(input int g);
      foreach (vecs[i]) if (vecs[i].grp == g) begin
         @(negedge clk);
         check("full_before_wr", full, vecs[i].exp_full);
         wr_en = 1'b1;
         wr_data = vecs[i].data;
         if (!vecs[i].exp_full) sb.push_back(vecs[i].data);
      end
      @(negedge clk);
      wr_en = 1'b0;
   endtask
   task automatic wait_idle();
      int n = 0;
      while ((busy || mon_active) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", n < 1000, 1);
   endtask
   initial begin
      logic [9:0] frame;
      int n;
      fork
         monitor();
      join_none
      vecs.push_back('{2, 8'hA5, 1'b0});
      for (int i = 1; i <= 3; i++) vecs.push_back('{3, 8'(i), 1'b0});
      for (int i = 0; i < 6; i++) vecs.push_back('{4, 8'(8'h10 + i), i == 5});
      for (int i = 0; i < 5; i++) vecs.push_back('{6, 8'(8'h20 + i), 1'b0});
      // reset and quiet idle
      repeat (3) @(negedge clk);
      check("reset_state", {tx, busy, full, overflow}, 4'b1000);
      reset = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         check("idle_outputs", {tx, busy, full, overflow}, 4'b1000);
      end
      // single byte: exact waveform and busy timing
      apply_group(2);
      check("tx_before_start", tx, 1);
      frame = {STOP_BIT, 8'hA5, START_BIT};
      for (int k = 0; k < FRAME_CYC; k++) begin
         @(negedge clk);
         check("a5_wave", tx, frame[k/CPB]);
         if (k == FRAME_CYC - 1) check("busy_last_stop", busy, 1);
      end
      @(negedge clk);
      check("busy_after_frame", busy, 0);
      check("tx_after_frame", tx, 1);
      wait_idle();
      // three bytes: contiguous frames
      starts.delete();
      apply_group(3);
      wait_idle();
      check("s3_frames", starts.size(), 3);
      if (starts.size() == 3) begin
         check("s3_gap01", starts[1] - starts[0], FRAME_CYC);
         check("s3_gap12", starts[2] - starts[1], FRAME_CYC);
      end
      // six bytes: last dropped, sticky overflow
      apply_group(4);
      check("ovf_set", overflow, 1);
      wait_idle();
      check("ovf_sticky_busy", {overflow, busy}, 2'b10);
      check("s4_sb_empty", sb.size(), 0);
      // reset mid-frame during data bit 3
      @(negedge clk);
      wr_en = 1'b1;
      wr_data = 8'hFF;
      sb.push_back(8'hFF);
      @(negedge clk);
      wr_en = 1'b0;
      n = 0;
      while (tx && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("s5_start_seen", tx, 0);
      repeat (CPB + 3 * CPB + 1) @(negedge clk);
      reset = 1'b0;
      sb.delete();
      @(negedge clk);
      check("s5_in_reset", {tx, busy, full, overflow}, 4'b1000);
      reset = 1'b1;
      @(negedge clk);
      check("s5_released", {tx, busy, full, overflow}, 4'b1000);
      starts.delete();
      n = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!tx) n++;
      end
      check("s5_no_frame_low", n, 0);
      check("s5_no_frame_starts", starts.size(), 0);
      // full FIFO: write collides with the pop at a frame end
      apply_group(6);
      repeat (FRAME_CYC - 1 - 3) @(negedge clk);
      check("s6_full_before", {full, overflow, tx}, 3'b101);
      wr_en = 1'b1;
      wr_data = 8'hEE;
      @(negedge clk);
      check("s6_dropped", {overflow, full, tx}, 3'b100);
      wr_data = 8'hE1;
      sb.push_back(8'hE1);
      @(negedge clk);
      wr_en = 1'b0;
      check("s6_refill_full", full, 1);
      wait_idle();
      check("s6_ovf_sticky", overflow, 1);
      check("final_sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
